// File: rtl/hpm_counters.sv
// RISC-V hardware performance monitor counters mhpmcounter3.. with mhpmevent selectors and CSR decode.
// Define HPM_OVF_IRQ_EN to enable sticky overflow (OF) flags and the ovf_irq request.
module hpm_counters #(
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_EVENTS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [11:0]           addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  hit,
    output logic                  illegal_csr,
    input  logic [1:0]            priv,
    input  logic [28:0]           inhibit,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  ovf_irq
);
    localparam int unsigned CW       = COUNTER_WIDTH;
    localparam logic [6:0]  PG_MLO   = 7'h58;  // 0xB00 >> 5
    localparam logic [6:0]  PG_MHI   = 7'h5C;  // 0xB80 >> 5
    localparam logic [6:0]  PG_EVT   = 7'h19;  // 0x320 >> 5
    localparam logic [6:0]  PG_ULO   = 7'h60;  // 0xC00 >> 5
    localparam logic [6:0]  PG_UHI   = 7'h64;  // 0xC80 >> 5

    logic [CW-1:0]           cnt_q [NUM_COUNTERS];
    logic [CW-1:0]           cnt_d [NUM_COUNTERS];
    logic [7:0]              sel_q [NUM_COUNTERS];
    logic [7:0]              sel_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] of_q, of_d;
    logic [NUM_EVENTS-1:0]   events_q;

    logic [6:0]   page;
    logic [4:0]   idx;
    logic         in_row, is_mlo, is_mhi, is_evt, is_ulo, is_uhi, wr_ok;
    logic [255:0] ev_ext;
    logic [63:0]  rd_cnt64, nx_cnt64;
    logic         wr_this;
    logic         unused_inhibit;

    assign unused_inhibit = ^inhibit;

    // Address decode: low five bits select index 3..31 within each 32-entry CSR page
    assign page   = addr[11:5];
    assign in_row = addr[4:0] >= 5'd3;
    assign idx    = addr[4:0] - 5'd3;
    assign is_mlo = in_row && (page == PG_MLO);
    assign is_mhi = in_row && (page == PG_MHI);
    assign is_evt = in_row && (page == PG_EVT);
    assign is_ulo = in_row && (page == PG_ULO);
    assign is_uhi = in_row && (page == PG_UHI);
    assign hit    = is_mlo | is_mhi | is_evt | is_ulo | is_uhi;

    assign illegal_csr = (rd_en | wr_en) & hit &
                         ((wr_en & (is_ulo | is_uhi)) |
                          ((priv != 2'd3) & (is_mlo | is_mhi | is_evt)));
    assign wr_ok = wr_en & hit & ~illegal_csr;

    // Read mux; unimplemented indices fall through to zero
    always_comb begin
        rd_data  = '0;
        rd_cnt64 = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (hit && (idx == 5'(i))) begin
                rd_cnt64 = 64'(cnt_q[i]);
                if (is_mlo || is_ulo) begin
                    rd_data = rd_cnt64[31:0];
                end else if (is_mhi || is_uhi) begin
                    rd_data = rd_cnt64[63:32];
                end else begin
                    rd_data = {of_q[i], 23'b0, sel_q[i]};
                end
            end
        end
    end

    // Bit 0 of ev_ext is a constant zero so that selector 0 never counts
    assign ev_ext = 256'({events_q, 1'b0});

    always_comb begin
        of_d     = of_q;
        nx_cnt64 = '0;
        wr_this  = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            wr_this  = wr_ok && (idx == 5'(i));
            nx_cnt64 = 64'(cnt_q[i]);
            if (wr_this && is_mlo) begin
                cnt_d[i] = CW'({nx_cnt64[63:32], wr_data});
            end else if (wr_this && is_mhi) begin
                cnt_d[i] = CW'({wr_data, nx_cnt64[31:0]});
            end else if (ev_ext[sel_q[i]] && !inhibit[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
`ifdef HPM_OVF_IRQ_EN
                if (&cnt_q[i]) begin
                    of_d[i] = 1'b1;
                end
`endif
            end
            // Event-register write wins over a same-cycle wrap
            if (wr_this && is_evt) begin
                sel_d[i] = (wr_data[7:0] > 8'(NUM_EVENTS)) ? 8'd0 : wr_data[7:0];
`ifdef HPM_OVF_IRQ_EN
                of_d[i]  = wr_data[31];
`endif
            end
        end
`ifndef HPM_OVF_IRQ_EN
        of_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_q <= '0;
            of_q     <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            events_q <= events;
            of_q     <= of_d;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
        end
    end

`ifdef HPM_OVF_IRQ_EN
    assign ovf_irq = |of_q;
`else
    assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counters.sv
// Self-checking bench for hpm_counters: directed scenarios plus randomized CSR traffic
// compared every cycle against an address-range based behavioural model.
module tb_hpm_counters;
    localparam int NC = 2;
    localparam int CW = 40;
    localparam int NE = 8;
    localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;
`ifdef HPM_OVF_IRQ_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0, wr_en = 1'b0;
    logic [11:0]   addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic          hit, illegal_csr, ovf_irq;
    logic [1:0]    priv = 2'd3;
    logic [28:0]   inhibit = '0;
    logic [NE-1:0] events = '0;

    int tests = 0;
    int fails = 0;

    hpm_counters #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(CW), .NUM_EVENTS(NE)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .hit(hit), .illegal_csr(illegal_csr),
        .priv(priv), .inhibit(inhibit), .events(events), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    // Reference state
    longint unsigned m_cnt [NC];
    int              m_sel [NC];
    bit              m_of  [NC];
    bit [NE-1:0]     m_ev;

    // kind: 0 none, 1 mhpmcounter, 2 mhpmcounterh, 3 mhpmevent, 4 hpmcounter, 5 hpmcounterh
    function automatic void decode(input logic [11:0] a, output int kind, output int k);
        int v;
        v = int'(a);
        kind = 0;
        k = 0;
        if (v >= 'hB03 && v <= 'hB1F) begin kind = 1; k = v - 'hB03; end
        else if (v >= 'hB83 && v <= 'hB9F) begin kind = 2; k = v - 'hB83; end
        else if (v >= 'h323 && v <= 'h33F) begin kind = 3; k = v - 'h323; end
        else if (v >= 'hC03 && v <= 'hC1F) begin kind = 4; k = v - 'hC03; end
        else if (v >= 'hC83 && v <= 'hC9F) begin kind = 5; k = v - 'hC83; end
    endfunction

    function automatic bit exp_ill(input int kind, input logic rd, input logic wr, input logic [1:0] pv);
        return (rd || wr) && (kind != 0) && ((wr && kind >= 4) || (pv != 2'd3 && kind <= 3));
    endfunction

    function automatic logic [31:0] exp_rd(input int kind, input int k);
        if (kind == 0 || k >= NC) return 32'd0;
        if (kind == 1 || kind == 4) return 32'(m_cnt[k]);
        if (kind == 2 || kind == 5) return 32'(m_cnt[k] >> 32);
        return {m_of[k], 23'b0, 8'(m_sel[k])};
    endfunction

    function automatic bit exp_irq();
        bit r = 1'b0;
        for (int j = 0; j < NC; j++) r |= m_of[j];
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model update at each active edge
    int  u_kind, u_k;
    bit  u_wr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NC; j++) begin
                m_cnt[j] = 0; m_sel[j] = 0; m_of[j] = 0;
            end
            m_ev = '0;
        end else begin
            decode(addr, u_kind, u_k);
            u_wr = wr_en && (u_kind != 0) && !exp_ill(u_kind, rd_en, wr_en, priv);
            for (int j = 0; j < NC; j++) begin
                if (u_wr && u_k == j && u_kind == 1)
                    m_cnt[j] = ((m_cnt[j] & ~64'hFFFF_FFFF) | longint'(wr_data)) & MASK;
                else if (u_wr && u_k == j && u_kind == 2)
                    m_cnt[j] = ((longint'(wr_data) << 32) | (m_cnt[j] & 64'hFFFF_FFFF)) & MASK;
                else if (m_sel[j] != 0 && m_ev[m_sel[j]-1] && !inhibit[j]) begin
                    m_cnt[j] = (m_cnt[j] + 1) & MASK;
                    if (m_cnt[j] == 0 && OVF) m_of[j] = 1'b1;
                end
                if (u_wr && u_k == j && u_kind == 3) begin
                    m_sel[j] = (int'(wr_data[7:0]) > NE) ? 0 : int'(wr_data[7:0]);
                    if (OVF) m_of[j] = wr_data[31];
                end
            end
            m_ev = events;
        end
    end

    // Continuous comparison of all outputs against the model
    int  c_kind, c_k;
    bit  c_ill;
    always @(negedge clk) begin
        if (rst_n) begin
            decode(addr, c_kind, c_k);
            c_ill = exp_ill(c_kind, rd_en, wr_en, priv);
            check("hit", 32'(hit), 32'(c_kind != 0));
            check("illegal_csr", 32'(illegal_csr), 32'(c_ill));
            if (!c_ill) check("rd_data", rd_data, exp_rd(c_kind, c_k));
            check("ovf_irq", 32'(ovf_irq), 32'(exp_irq()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b0;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [11:0] a, input logic [31:0] exp_d, input logic exp_hit);
        logic [11:0] sa;
        logic        sr, sw;
        sa = addr; sr = rd_en; sw = wr_en;
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        #1;
        check({nm, " data"}, rd_data, exp_d);
        check({nm, " hit"}, 32'(hit), 32'(exp_hit));
        check({nm, " illegal"}, 32'(illegal_csr), 32'd0);
        addr = sa; rd_en = sr; wr_en = sw;
    endtask

    task automatic ill_probe(input string nm, input logic [11:0] a, input logic wr, input logic exp_i);
        addr = a; rd_en = ~wr; wr_en = wr;
        #1;
        check(nm, 32'(illegal_csr), 32'(exp_i));
    endtask

    initial begin
        logic [11:0] bases [7];
        int          op;
        bases = '{12'hB03, 12'hB83, 12'h323, 12'hC03, 12'hC83, 12'h300, 12'hB00};

        // Reset state
        #2;
        peek("reset B03", 12'hB03, 32'd0, 1'b1);
        check("reset ovf_irq", 32'(ovf_irq), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Non-HPM addresses
        peek("nohit 300", 12'h300, 32'd0, 1'b0);
        peek("nohit B02", 12'hB02, 32'd0, 1'b0);
        peek("nohit B20", 12'hB20, 32'd0, 1'b0);

        // Five pulses on events[1] with sel=2
        csr_wr(12'h323, 32'd2);
        events = 8'h02;
        cyc();
        peek("cnt after 1st sample", 12'hB03, 32'd0, 1'b1);
        cyc();
        peek("cnt first inc", 12'hB03, 32'd1, 1'b1);
        cyc(); cyc(); cyc();
        events = 8'h00;
        cyc();
        peek("cnt five", 12'hB03, 32'd5, 1'b1);
        cyc();
        peek("cnt holds", 12'hB03, 32'd5, 1'b1);

        // Wrap from all ones
        csr_wr(12'hB83, 32'hFFFF_FFFF);
        csr_wr(12'hB03, 32'hFFFF_FFFE);
        peek("hi bits 39:32", 12'hB83, 32'h0000_00FF, 1'b1);
        csr_wr(12'h323, 32'd1);
        events = 8'h01;
        cyc(); cyc();
        events = 8'h00;
        cyc();
        peek("wrap lo", 12'hB03, 32'd0, 1'b1);
        peek("wrap hi", 12'hB83, 32'd0, 1'b1);
        peek("wrap evt", 12'h323, OVF ? 32'h8000_0001 : 32'h0000_0001, 1'b1);
        check("wrap ovf_irq", 32'(ovf_irq), 32'(OVF));
        csr_wr(12'h323, 32'd1);
        check("of cleared irq", 32'(ovf_irq), 32'd0);

        // Write collides with a pending increment
        events = 8'h01;
        cyc();
        events = 8'h00;
        addr = 12'hB03; wr_data = 32'h0000_1234; wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
        peek("write wins", 12'hB03, 32'h0000_1234, 1'b1);
        cyc();
        peek("no late inc", 12'hB03, 32'h0000_1234, 1'b1);

        // U-mode privilege rules
        priv = 2'd0;
        peek("U read C03", 12'hC03, 32'h0000_1234, 1'b1);
        wr_data = 32'h0000_DEAD;
        ill_probe("U write C03 illegal", 12'hC03, 1'b1, 1'b1);
        cyc();
        ill_probe("U read B03 illegal", 12'hB03, 1'b0, 1'b1);
        wr_data = 32'h0000_BEEF;
        ill_probe("U write B03 illegal", 12'hB03, 1'b1, 1'b1);
        cyc();
        wr_data = 32'h0000_0005;
        ill_probe("U write 323 illegal", 12'h323, 1'b1, 1'b1);
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        priv = 2'd3;
        ill_probe("M write C03 illegal", 12'hC03, 1'b1, 1'b1);
        cyc();
        wr_en = 1'b0;
        peek("state unchanged", 12'hB03, 32'h0000_1234, 1'b1);
        peek("sel unchanged", 12'h323, 32'd1, 1'b1);

        // Unimplemented index and WARL selector
        peek("unimpl B05", 12'hB05, 32'd0, 1'b1);
        csr_wr(12'hB05, 32'h55);
        peek("unimpl write ignored", 12'hB05, 32'd0, 1'b1);
        csr_wr(12'h324, 32'd200);
        peek("sel 200 -> 0", 12'h324, 32'd0, 1'b1);
        csr_wr(12'h324, 32'd8);
        peek("sel 8 kept", 12'h324, 32'd8, 1'b1);
        csr_wr(12'h324, 32'd9);
        peek("sel 9 -> 0", 12'h324, 32'd0, 1'b1);

        // Reset mid-count with events active
        events = 8'hFF;
        cyc(); cyc();
        #1 rst_n = 1'b0;
        peek("rst lo", 12'hB03, 32'd0, 1'b1);
        peek("rst evt", 12'h323, 32'd0, 1'b1);
        check("rst ovf_irq", 32'(ovf_irq), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        peek("post rst no count", 12'hB03, 32'd0, 1'b1);
        events = 8'h00;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            priv    = ($urandom % 8 == 0) ? 2'd0 : 2'd3;
            events  = NE'($urandom & $urandom);
            inhibit = ($urandom % 6 == 0) ? 29'($urandom) : 29'd0;
            op      = int'($urandom % 4);
            addr    = bases[$urandom % 7] + 12'($urandom % 4);
            rd_en   = (op == 1 || op == 3);
            wr_en   = (op == 2);
            case ($urandom % 5)
                0:       wr_data = 32'hFFFF_FFFF;
                1:       wr_data = 32'hFFFF_FFF0 | 32'($urandom % 16);
                2:       wr_data = {$urandom % 2 == 0, 23'b0, 8'($urandom % 12)};
                3:       wr_data = 32'h0000_00FF;
                default: wr_data = $urandom;
            endcase
            if ($urandom % 500 == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end
        rd_en = 1'b0; wr_en = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hpm_counters.md
HPM_COUNTERS -- requirements
Module: hpm_counters

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 4: implemented counters mhpmcounter3..mhpmcounter(2+NUM_COUNTERS), legal range 1..29.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 64: implemented counter bits, legal range 32..64.
REQ-003 SHALL have parameter NUM_EVENTS, default 8: number of event inputs, legal range 1..255.
REQ-004 SHALL have ports:
 clk  in  1  global system clock
 rst_n  in  1  reset; one clock; reset is asynchronous and active-low
 rd_en  in  1  CSR read enable
 wr_en  in  1  CSR write enable
 addr  in  12  CSR address
 wr_data  in  32  CSR write data
 rd_data  out  32  CSR read data, combinational
 hit  out  1  addr decodes to an HPM CSR (0xB03-0xB1F, 0xB83-0xB9F, 0x323-0x33F, 0xC03-0xC1F, 0xC83-0xC9F)
 illegal_csr  out  1  access not permitted
 priv  in  2  current privilege (0=U, 3=M)
 inhibit  in  29  mcountinhibit[31:3]; bit i-3 freezes counter i
 events  in  NUM_EVENTS  one-cycle event pulses
 ovf_irq  out  1  local count-overflow interrupt request

Function
REQ-005 Each counter i SHALL own a COUNTER_WIDTH counter and an mhpmevent register: selector sel_i in bits [7:0], OF in bit 31.
REQ-006 events SHALL be registered once; counter i SHALL increment by 1 at edge N+1 when events[sel_i-1] is high at edge N, sel_i is nonzero, and inhibit bit is 0 at edge N+1.
REQ-007 sel_i writes >NUM_EVENTS SHALL store 0 (WARL); sel_i=0 SHALL count nothing.
REQ-008 Reads of 0xB03+k/0xC03+k SHALL return counter[31:0]; 0xB83+k/0xC83+k SHALL return counter bits above 31, zero-extended; bits >= COUNTER_WIDTH read 0.
REQ-009 Reads of 0x323+k SHALL return {OF, 23'b0, sel}.
REQ-010 Indices k >= NUM_COUNTERS SHALL read 0, ignore writes, and not be illegal in M-mode.
REQ-011 Writes to 0xB03+k/0xB83+k SHALL load that half at the next edge; that counter SHALL not increment that cycle; other half holds.
REQ-012 illegal_csr SHALL be (rd_en|wr_en) & hit & (wr_en to 0xCxx, or priv!=3 to 0xB/0x3 ranges); illegal writes SHALL not update state.
REQ-013 U-mode reads of 0xC03-0xC9F SHALL be legal.
REQ-014 An increment from all-ones SHALL wrap the counter to 0.
REQ-015 When hit=0, rd_data SHALL be 0 and illegal_csr SHALL be 0.

Reset
REQ-016 On rst_n low, counters, sel, OF, and the event register SHALL clear asynchronously; ovf_irq SHALL be 0.
REQ-017 Reset deasserted mid-count SHALL discard any registered events; first count requires a fresh event after release.

Configuration
REQ-018 Macro HPM_OVF_IRQ_EN defined: a wrap per REQ-014 SHALL set OF_i at the same edge; OF is sticky, cleared only by a write of mhpmevent with bit31=0; software may set OF; ovf_irq SHALL be the OR of all OF bits, registered state only.
REQ-019 Macro HPM_OVF_IRQ_EN undefined: OF SHALL read 0, writes to bit 31 SHALL be ignored, ovf_irq SHALL be tied 0.
REQ-020 Simultaneous wrap and mhpmevent write to the same counter SHALL take the written OF value.

Verification
REQ-021 sel3=2, events[1] pulse 5 cycles -> mhpmcounter3 reads 5, first increment 2 edges after first pulse.
REQ-022 Write 0xB83=0xFFFFFFFF and 0xB03=0xFFFFFFFE, sel=1, 2 pulses -> counter 0; OF=1 and ovf_irq=1 with macro, 0 without.
REQ-023 Write mhpmcounter3 in same cycle as event -> reads written value, no increment.
REQ-024 priv=0: read 0xC03 legal; write 0xC03 or read 0xB03 -> illegal_csr=1, state unchanged.
REQ-025 NUM_COUNTERS=2, COUNTER_WIDTH=40: read 0xB05 -> 0, no illegal; mhpmcounter3h reads bits [39:32] only; write sel=200 with NUM_EVENTS=8 -> reads 0.
REQ-026 Assert rst_n low mid-count with events active -> all reads 0, ovf_irq=0 immediately, no count on first post-reset edge.
